// File: rtl/fb_scan_pkg.sv
// Shared definitions for the frame-buffer scanner: FSM encoding, FIFO sizing,
// default frame geometry and a counter-width helper.
// Latency: n/a (package). Backpressure: n/a.
package fb_scan_pkg;

  // Scanner FSM: IDLE waits for start, FETCH issues raster-order reads,
  // DRAIN waits for the last pixel to leave the FIFO.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  // Pixel FIFO depth; also the read-credit limit (fifo_count + inflight).
  localparam int FIFO_DEPTH = 4;
  // Count width must represent 0..FIFO_DEPTH inclusive.
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

  // Default frame geometry and bus widths.
  localparam int FB_W_DEF = 256;
  localparam int FB_H_DEF = 256;
  localparam int DW_DEF   = 24;
  localparam int AW_DEF   = 20;

  // Width of a counter that spans 0..n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fb_scan_if.sv
// Bus bundle between the scanner, its image memory and its pixel sink.
// Latency: n/a (wiring only). Backpressure: pix_ready from the sink.
// Ports: im_a/im_ren_n/im_q (memory read port, data one cycle after strobe),
//        pix_data/pix_valid/pix_ready/pix_sol/pix_eof (pixel stream).
interface fb_scan_if
  import fb_scan_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) ();

  // Image-memory read port
  logic [AW-1:0] im_a;
  logic          im_ren_n;
  logic [DW-1:0] im_q;

  // Pixel stream towards the display sink
  logic [DW-1:0] pix_data;
  logic          pix_valid;
  logic          pix_ready;
  logic          pix_sol;
  logic          pix_eof;

  // Scanner side
  modport master (
    output im_a,
    output im_ren_n,
    input  im_q,
    output pix_data,
    output pix_valid,
    input  pix_ready,
    output pix_sol,
    output pix_eof
  );

  // Memory + sink side
  modport slave (
    input  im_a,
    input  im_ren_n,
    output im_q,
    input  pix_data,
    input  pix_valid,
    output pix_ready,
    input  pix_sol,
    input  pix_eof
  );

endinterface

// File: rtl/fb_scan_fifo.sv
// Small synchronous FIFO holding returned pixels with their sol/eof tags.
// Latency: write visible at the head one cycle after push.
// Backpressure: push is dropped only when full and not popping (the caller's
// credit scheme never lets that happen); pop is ignored when empty.
// Ports: clk, reset (async active-low), push/push_dat, pop, head_dat, empty, count.
module fb_fifo
  import fb_scan_pkg::*;
#(
  parameter int W = DW_DEF + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [W-1:0]       push_dat,
  input  logic               pop,
  output logic [W-1:0]       head_dat,
  output logic               empty,
  output logic [FIFO_CW-1:0] count
);

  localparam int PW = $clog2(FIFO_DEPTH);

  logic [W-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FIFO_CW'(FIFO_DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO can still accept a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign head_dat = mem[rd_ptr];

  // Storage needs no reset: entries are only observed once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Simultaneous push and pop leave the occupancy unchanged.
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fb_scan.sv
// Frame-buffer scanner: reads one FB_W x FB_H frame in raster order from image
// memory starting at a sampled base address and streams it to a pixel sink.
// Latency: first pix_valid two clock edges after the edge that samples start;
// then one pixel per cycle while pix_ready is high.
// Backpressure: pix_ready low stalls the sink side; reads are throttled by a
// credit of FIFO_DEPTH (fifo_count + inflight) so the FIFO can never overflow.
// Ports: clk, reset (async active-low), start/fb_addr (frame request),
//        busy/frame_done (status), bus (memory read port + pixel stream).
module fb_scan
  import fb_scan_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int AW   = AW_DEF,
  parameter int FB_W = FB_W_DEF,
  parameter int FB_H = FB_H_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] fb_addr,
  output logic          busy,
  output logic          frame_done,
  fb_scan_if.master     bus
);

  localparam int XW = cnt_width(FB_W);
  localparam int YW = cnt_width(FB_H);
  localparam logic [XW-1:0]      X_LAST  = XW'(FB_W - 1);
  localparam logic [YW-1:0]      Y_LAST  = YW'(FB_H - 1);
  localparam logic [FIFO_CW:0]   CREDITS = (FIFO_CW + 1)'(FIFO_DEPTH);

  scan_state_t state_q;
  scan_state_t state_d;

  logic [XW-1:0]      x_q;
  logic [YW-1:0]      y_q;
  // Running read pointer: always equals base + y*FB_W + x (mod 2^AW), because
  // raster order advances the linear offset by exactly one per read.
  logic [AW-1:0]      rd_addr_q;
  // A read was issued last cycle, so im_q carries data this cycle.
  logic               inflight_q;
  // Tags of the read that is in flight, travelling alongside im_q.
  logic               sol_tag_q;
  logic               eof_tag_q;

  logic               issue;
  logic               last_px;
  logic [FIFO_CW:0]   credit_used;

  logic               fifo_pop;
  logic               fifo_empty;
  logic [FIFO_CW-1:0] fifo_count;
  logic [DW+1:0]      fifo_head;
  logic               eof_pop;

  assign last_px     = (x_q == X_LAST) && (y_q == Y_LAST);
  assign credit_used = {1'b0, fifo_count} + {{FIFO_CW{1'b0}}, inflight_q};

  // FIFO entry layout: {pixel, sol, eof}
  assign fifo_pop = !fifo_empty && bus.pix_ready;
  assign eof_pop  = fifo_pop && fifo_head[0];

  // ------------------------------------------------------------------
  // FSM: next state and read issue
  // ------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        issue = (credit_used < CREDITS);
        if (issue && last_px) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (eof_pop) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------------------------
  // State, raster counters and read pipeline
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      rd_addr_q  <= '0;
      inflight_q <= 1'b0;
      sol_tag_q  <= 1'b0;
      eof_tag_q  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      frame_done <= eof_pop;
      if (state_q == ST_IDLE && start) begin
        x_q       <= '0;
        y_q       <= '0;
        rd_addr_q <= fb_addr;
      end else if (issue) begin
        sol_tag_q <= (x_q == '0);
        eof_tag_q <= last_px;
        rd_addr_q <= rd_addr_q + 1'b1;
        if (x_q == X_LAST) begin
          x_q <= '0;
          y_q <= (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end else begin
          x_q <= x_q + 1'b1;
        end
      end
    end
  end

  // ------------------------------------------------------------------
  // Returned pixels land in the FIFO the cycle they are on im_q
  // ------------------------------------------------------------------
  fb_fifo #(
    .W (DW + 2)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_dat ({bus.im_q, sol_tag_q, eof_tag_q}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // ------------------------------------------------------------------
  // Outputs
  // ------------------------------------------------------------------
  // im_a is the pointer register, so it holds whenever no read is issued.
  assign bus.im_ren_n  = !issue;
  assign bus.im_a      = rd_addr_q;
  assign bus.pix_valid = !fifo_empty;
  assign bus.pix_data  = fifo_head[DW+1:2];
  // Tags are gated so stale storage never shows when the FIFO is empty.
  assign bus.pix_sol   = !fifo_empty && fifo_head[1];
  assign bus.pix_eof   = !fifo_empty && fifo_head[0];
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/fb_scan.md
FB_SCAN -- requirements
Module: fb_scan

Interface
REQ-001 Parameter DW, default 24, pixel/memory data width in bits.
REQ-002 Parameter AW, default 20, image-memory address width in bits.
REQ-003 Parameter FB_W, default 256, pixels per line; FB_H, default 256, lines per frame.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to scan one frame; honoured only in IDLE.
REQ-007 fb_addr  input  AW  frame-buffer base address, sampled when start is honoured.
REQ-008 im_a  output  AW  image-memory read address.
REQ-009 im_ren_n  output  1  active-low read strobe; im_q valid exactly one cycle later.
REQ-010 im_q  input  DW  image-memory read data.
REQ-011 pix_data  output  DW  pixel to display sink.
REQ-012 pix_valid  output  1  pix_data/pix_sol/pix_eof valid.
REQ-013 pix_ready  input  1  sink accepts when pix_valid and pix_ready are both high.
REQ-014 pix_sol  output  1  first pixel of a line.
REQ-015 pix_eof  output  1  last pixel of the frame.
REQ-016 busy  output  1  high from the cycle after an honoured start until frame_done.
REQ-017 frame_done  output  1  one-cycle pulse in the cycle after the pix_eof beat is accepted.

Function
REQ-018 FSM states: IDLE, FETCH, DRAIN; IDLE->FETCH on start; FETCH->DRAIN after the read of pixel FB_W*FB_H-1 is issued; DRAIN->IDLE when the pix_eof beat is accepted.
REQ-019 Read address = base + y*FB_W + x, modulo 2^AW (wrap-around, no error); x,y reset to 0 on honoured start.
REQ-020 x increments per issued read; x==FB_W-1 wraps x to 0 and increments y; reads issued in raster order only.
REQ-021 A read is issued (im_ren_n=0) in FETCH only when fifo_count + inflight < 4 (credit rule); otherwise im_ren_n=1 and im_a holds its value.
REQ-022 Every returned im_q is written to the internal FIFO together with its sol (x==0) and eof (last pixel) tags; FIFO never overflows.
REQ-023 pix_valid = FIFO not empty; pix outputs come from FIFO head; a beat pops on pix_valid&&pix_ready.
REQ-024 Simultaneous push and pop in one cycle leaves fifo_count unchanged.
REQ-025 With pix_ready held high, first pix_valid appears 2 cycles after start and one pixel is delivered per cycle thereafter.
REQ-026 pix_ready low for any duration stalls delivery without loss, duplication or reordering.
REQ-027 start while busy is ignored; fb_addr changes while busy have no effect.
REQ-028 im_ren_n is 1 in IDLE and DRAIN.

Reset
REQ-029 reset low: state=IDLE, x=y=0, FIFO and inflight flag empty, im_ren_n=1, im_a=0, pix_valid=0, pix_sol=0, pix_eof=0, busy=0, frame_done=0.
REQ-030 reset asserted mid-frame aborts immediately; no pixels from the aborted frame appear after reset release.

Structure
REQ-031 Shared package holds FSM state encoding (2 bits), FIFO depth 4, and the frame-size constants.
REQ-032 One sub-module, fb_fifo: 4-entry synchronous FIFO of DW+2 bits with count output, same clk/reset.

Verification
REQ-033 fb_addr=0x10000, start, pix_ready=1 -> first read im_a=0x10000; 65536 beats, data equals memory model in order, frame_done one cycle after last beat.
REQ-034 Random pix_ready (50%) -> same 65536-beat sequence, FIFO count never exceeds 4, no drop/duplicate.
REQ-035 pix_sol high exactly on beats 0,256,...,65280; pix_eof only on beat 65535.
REQ-036 fb_addr=0xFFF00 -> addresses wrap past 0xFFFFF to 0x00000 and continue without error.
REQ-037 start pulsed again at beat 1000 -> ignored, frame completes normally; reset low at beat 5000 -> all outputs at reset values, next start scans a clean frame.
